// File: rtl/cdb_driver_pkg.sv
// Shared types for the common-data-bus driver: ROB tag, LC-3b word and the
// registered broadcast record.
package cdb_driver_pkg;

   localparam int CDB_NUM_STATIONS = 4;
   localparam int TAG_W            = 3;
   localparam int WORD_W           = 16;

   typedef logic [WORD_W-1:0] lc3b_word;
   typedef logic [TAG_W-1:0]  lc3b_tag;

   typedef struct packed {
      logic     valid;
      lc3b_tag  tag;
      lc3b_word data;
   } cdb_t;

endpackage

// File: rtl/cdb_driver_onehot_decoder.sv
// Enabled index-to-one-hot decoder; indices outside 0..N-1 decode to zero.
module onehot_decoder #(
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             en,
   input  logic [SEL_W-1:0] sel,
   output logic [N-1:0]     onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (en && (sel == SEL_W'(i))) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/cdb_driver.sv
// Registers the arbitrator-selected station result onto the CDB behind a
// single-entry ready/valid output stage, and pulses a clear to that station.
module cdb_driver
   import cdb_driver_pkg::*;
#(
   parameter int NUM_STATIONS = CDB_NUM_STATIONS,
   parameter int SEL_W        = $clog2(NUM_STATIONS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [SEL_W-1:0]  selection,
   input  lc3b_tag           station_tag  [NUM_STATIONS],
   input  lc3b_word          station_data [NUM_STATIONS],
   input  logic              rob_ready,
   input  logic              flush,
   output logic              cdb_valid,
   output lc3b_tag           cdb_tag,
   output lc3b_word          cdb_data,
   output logic [NUM_STATIONS-1:0] station_clear,
   output logic              busy,
   output logic [15:0]       bcast_count
);

   cdb_t                    cdb_q, cdb_d;
   logic [NUM_STATIONS-1:0] clear_d;
   logic                    sel_in_range;
   logic                    accept, capture;
   lc3b_tag                 sel_tag;
   lc3b_word                sel_data;

   // Loop-compare mux keeps an out-of-range index from ever reading past the array.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      sel_in_range = 1'b0;
      sel_tag      = '0;
      sel_data     = '0;
      for (int i = 0; i < NUM_STATIONS; i++) begin
         if (selection == SEL_W'(i)) begin
            sel_in_range = 1'b1;
            sel_tag      = station_tag[i];
            sel_data     = station_data[i];
         end
      end
   end

   assign accept  = cdb_q.valid && rob_ready;
   assign capture = load && !flush && sel_in_range && (!cdb_q.valid || rob_ready);

   // Implicit EMPTY/FULL state is cdb_q.valid; next-state logic lives here.
   always_comb begin
      cdb_d = cdb_q;
      if (capture) begin
         cdb_d.valid = 1'b1;
         cdb_d.tag   = sel_tag;
         cdb_d.data  = sel_data;
      end else if (accept || flush) begin
         cdb_d.valid = 1'b0;
      end
   end

   onehot_decoder #(.N(NUM_STATIONS), .SEL_W(SEL_W)) u_clear_dec (
      .en     (capture),
      .sel    (selection),
      .onehot (clear_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cdb_q         <= '0;
         station_clear <= '0;
         bcast_count   <= '0;
      end else begin
         cdb_q         <= cdb_d;
         station_clear <= clear_d;
         if (accept) bcast_count <= bcast_count + 16'd1;
      end
   end

   assign cdb_valid = cdb_q.valid;
   assign cdb_tag   = cdb_q.tag;
   assign cdb_data  = cdb_q.data;
   assign busy      = cdb_q.valid && !rob_ready;

endmodule

// File: tb/tb_cdb_driver.sv
// Self-checking bench for cdb_driver: vector table plus a broadcast scoreboard
// and hand sequences for out-of-range grants, counter wrap and mid-run reset.
module tb_cdb_driver;
   import cdb_driver_pkg::*;

   logic       clk = 1'b0;
   logic       reset, load, rob_ready, flush;
   logic [1:0] selection;
   lc3b_tag    station_tag  [4];
   lc3b_word   station_data [4];
   logic       cdb_valid, busy;
   lc3b_tag    cdb_tag;
   lc3b_word   cdb_data;
   logic [3:0] station_clear;
   logic [15:0] bcast_count;

   // A 2-bit index cannot name station 4, so a 3-station instance covers the out-of-range grant.
   lc3b_tag    s3_tag  [3];
   lc3b_word   s3_data [3];
   logic       s3_valid, s3_busy;
   lc3b_tag    s3_cdb_tag;
   lc3b_word   s3_cdb_data;
   logic [2:0] s3_clear;
   logic [15:0] s3_count;

   cdb_driver dut (
      .clk(clk), .reset(reset), .load(load), .selection(selection),
      .station_tag(station_tag), .station_data(station_data),
      .rob_ready(rob_ready), .flush(flush),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .station_clear(station_clear), .busy(busy), .bcast_count(bcast_count)
   );

   cdb_driver #(.NUM_STATIONS(3)) dut3 (
      .clk(clk), .reset(reset), .load(load), .selection(selection),
      .station_tag(s3_tag), .station_data(s3_data),
      .rob_ready(rob_ready), .flush(flush),
      .cdb_valid(s3_valid), .cdb_tag(s3_cdb_tag), .cdb_data(s3_cdb_data),
      .station_clear(s3_clear), .busy(s3_busy), .bcast_count(s3_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       load;
      logic [1:0] sel;
      logic       rdy;
      logic       flush;
      logic       exp_valid;
      logic [3:0] exp_clear;
      logic [15:0] exp_count;
   } vec_t;

   typedef struct {
      lc3b_tag    tag;
      lc3b_word   data;
      logic [3:0] clear;
   } bcast_t;

   vec_t   vecs [14];
   bcast_t sb [$];
   bcast_t last;
   int     tests = 0;
   int     fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic l, input logic [1:0] s, input logic r, input logic f);
      load = l; selection = s; rob_ready = r; flush = f;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [1:0] s);
      bcast_t b;
      b.tag   = station_tag[s];
      b.data  = station_data[s];
      b.clear = 4'b0001 << s;
      sb.push_back(b);
   endtask

   // A clear pulse marks a fresh broadcast; otherwise a valid CDB must hold the last one.
   task automatic sb_check(input string name);
      if (station_clear != 4'b0000) begin
         if (sb.size() == 0) begin
            check({name, "_unexpected_bcast"}, {28'd0, station_clear}, 32'd0);
         end else begin
            last = sb.pop_front();
            check({name, "_tag"},   {29'd0, cdb_tag},       {29'd0, last.tag});
            check({name, "_data"},  {16'd0, cdb_data},      {16'd0, last.data});
            check({name, "_clear"}, {28'd0, station_clear}, {28'd0, last.clear});
         end
      end else if (cdb_valid) begin
         check({name, "_hold_tag"},  {29'd0, cdb_tag},  {29'd0, last.tag});
         check({name, "_hold_data"}, {16'd0, cdb_data}, {16'd0, last.data});
      end
   endtask

   function automatic vec_t mk(input logic l, input logic [1:0] s, input logic r, input logic f,
                               input logic v, input logic [3:0] c, input logic [15:0] n);
      vec_t t;
      t.load = l; t.sel = s; t.rdy = r; t.flush = f;
      t.exp_valid = v; t.exp_clear = c; t.exp_count = n;
      return t;
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      station_tag  = '{3'd1, 3'd6, 3'd5, 3'd3};
      station_data = '{16'hA0A0, 16'hB1B1, 16'h1234, 16'hD3D3};
      s3_tag       = '{3'd2, 3'd4, 3'd7};
      s3_data      = '{16'h1111, 16'h2222, 16'h3333};

      //                load sel rdy fl  valid clear   count
      vecs[0]  = mk(1, 2'd2, 1, 0, 1, 4'b0100, 16'd0);  // first grant
      vecs[1]  = mk(0, 2'd0, 1, 0, 0, 4'b0000, 16'd1);  // drain, clear gone
      vecs[2]  = mk(1, 2'd0, 1, 0, 1, 4'b0001, 16'd1);
      vecs[3]  = mk(1, 2'd3, 1, 0, 1, 4'b1000, 16'd2);  // back-to-back, no bubble
      vecs[4]  = mk(0, 2'd0, 1, 0, 0, 4'b0000, 16'd3);
      vecs[5]  = mk(1, 2'd1, 1, 0, 1, 4'b0010, 16'd3);
      vecs[6]  = mk(1, 2'd0, 0, 0, 1, 4'b0000, 16'd3);  // stall, load ignored
      vecs[7]  = mk(1, 2'd0, 0, 0, 1, 4'b0000, 16'd3);
      vecs[8]  = mk(1, 2'd0, 0, 0, 1, 4'b0000, 16'd3);
      vecs[9]  = mk(1, 2'd0, 1, 0, 1, 4'b0001, 16'd4);  // release: st0 broadcast
      vecs[10] = mk(1, 2'd2, 0, 1, 0, 4'b0000, 16'd4);  // flush while stalled
      vecs[11] = mk(1, 2'd1, 1, 0, 1, 4'b0010, 16'd4);
      vecs[12] = mk(1, 2'd3, 1, 1, 0, 4'b0000, 16'd5);  // flush + accept still counts
      vecs[13] = mk(0, 2'd0, 1, 0, 0, 4'b0000, 16'd5);

      reset = 1'b1;
      step(0, 2'd0, 0, 0);
      step(0, 2'd0, 0, 0);
      reset = 1'b0;
      check("rst_valid", {31'd0, cdb_valid},     32'd0);
      check("rst_tag",   {29'd0, cdb_tag},       32'd0);
      check("rst_data",  {16'd0, cdb_data},      32'd0);
      check("rst_clear", {28'd0, station_clear}, 32'd0);
      check("rst_count", {16'd0, bcast_count},   32'd0);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].exp_clear != 4'b0000) push(vecs[i].sel);
         step(vecs[i].load, vecs[i].sel, vecs[i].rdy, vecs[i].flush);
         check($sformatf("v%0d_valid", i), {31'd0, cdb_valid},     {31'd0, vecs[i].exp_valid});
         check($sformatf("v%0d_clear", i), {28'd0, station_clear}, {28'd0, vecs[i].exp_clear});
         check($sformatf("v%0d_count", i), {16'd0, bcast_count},   {16'd0, vecs[i].exp_count});
         check($sformatf("v%0d_busy", i),  {31'd0, busy},
               {31'd0, vecs[i].exp_valid && !vecs[i].rdy});
         sb_check($sformatf("v%0d_sb", i));
      end
      check("sb_drained", sb.size(), 32'd0);

      // Out-of-range grant on the 3-station instance is ignored; a valid one still works.
      step(1, 2'd3, 1, 0);
      check("oor_valid", {31'd0, s3_valid}, 32'd0);
      check("oor_clear", {29'd0, s3_clear}, 32'd0);
      step(1, 2'd2, 1, 0);
      check("s3_valid", {31'd0, s3_valid},    32'd1);
      check("s3_clear", {29'd0, s3_clear},    32'd4);
      check("s3_tag",   {29'd0, s3_cdb_tag},  32'd7);
      check("s3_data",  {16'd0, s3_cdb_data}, 32'h3333);

      // Run the counter up to the wrap point with one accept per cycle.
      reset = 1'b1;
      step(0, 2'd0, 1, 0);
      reset = 1'b0;
      for (int i = 0; i < 65535; i++) step(1, 2'(i), 1, 0);
      check("wrap_fffe", {16'd0, bcast_count}, 32'h0000FFFE);
      step(1, 2'd1, 1, 0);
      check("wrap_ffff", {16'd0, bcast_count}, 32'h0000FFFF);
      step(1, 2'd2, 1, 0);
      check("wrap_0000", {16'd0, bcast_count}, 32'h00000000);
      step(1, 2'd3, 1, 0);
      check("wrap_0001", {16'd0, bcast_count}, 32'h00000001);
      check("pre_reset_valid", {31'd0, cdb_valid}, 32'd1);

      // Reset in the middle of a live broadcast, with a competing grant.
      reset = 1'b1;
      step(1, 2'd2, 1, 0);
      reset = 1'b0;
      check("mid_rst_valid", {31'd0, cdb_valid},     32'd0);
      check("mid_rst_tag",   {29'd0, cdb_tag},       32'd0);
      check("mid_rst_data",  {16'd0, cdb_data},      32'd0);
      check("mid_rst_clear", {28'd0, station_clear}, 32'd0);
      check("mid_rst_count", {16'd0, bcast_count},   32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cdb_driver.md
Name: cdb_driver

Overview:
Downstream of the reservation-station arbitrator. Takes the arbitrator's `load`/`selection` grant and muxes the selected station's tag and result. Registers them onto the common data bus (CDB) for the ROB, register file and all stations, then pulses a one-hot clear back to the granted station. A single-entry output register with a ready/valid handshake to the ROB supports back-pressure and flush.

Parameters:
NUM_STATIONS, `NUM_STATIONS (4), number of reservation stations arbitrated.
SEL_W, $clog2(NUM_STATIONS) (2), width of the selection index.
TAG_W, 3, width of the ROB tag carried on the CDB.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
load  in  1  arbitrator grant valid.
selection  in  SEL_W  arbitrator-chosen station index.
station_tag  in  NUM_STATIONS x TAG_W  per-station destination ROB tag.
station_data  in  NUM_STATIONS x 16 (lc3b_word)  per-station result.
rob_ready  in  1  consumer accepts the current broadcast this cycle.
flush  in  1  pipeline flush (branch mispredict); kills pending and incoming broadcasts.
cdb_valid  out  1  broadcast valid.
cdb_tag  out  TAG_W  broadcast tag.
cdb_data  out  16  broadcast value.
station_clear  out  NUM_STATIONS  one-hot, one-cycle pulse freeing the granted station.
busy  out  1  output register occupied and not draining this cycle (combinational: cdb_valid && !rob_ready).
bcast_count  out  16  count of accepted broadcasts, for performance.

Behaviour:
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, station_clear=0, bcast_count=0. Reset overrides every other input in the same cycle.
- accept = cdb_valid && rob_ready; the broadcast retires that cycle.
- capture = load && !flush && (selection < NUM_STATIONS) && (!cdb_valid || rob_ready).
- On capture at edge N: cdb_tag/cdb_data <= station_tag/station_data[selection]; cdb_valid <= 1; station_clear <= one-hot(selection) for exactly one cycle.
- Latency: the grant in cycle N is visible on the CDB in cycle N+1, together with the clear pulse.
- accept without capture: cdb_valid <= 0.
- accept and capture in the same cycle: back-to-back broadcast; cdb_valid stays 1 and fields update. No bubble.
- cdb_valid=1, rob_ready=0 (stall):
  - Hold tag and data stable.
  - A concurrent load is ignored; no clear is issued. The station stays complete and the arbitrator re-grants later.
- flush:
  - Next cycle cdb_valid <= 0 and station_clear <= 0, regardless of load or rob_ready.
  - A broadcast accepted in the flush cycle still counts.
- selection >= NUM_STATIONS with load=1: treated as no grant; no state change.
- station_clear is 0 in every cycle not immediately following a capture. It never has more than one bit set.
- bcast_count increments by 1 on each accept and wraps 0xFFFF -> 0x0000.
- States are implicit, via cdb_valid:
  - EMPTY (cdb_valid=0) -> FULL on capture.
  - FULL -> FULL on accept with capture, or on stall.
  - FULL -> EMPTY on accept without capture, or on flush.

Decomposition:
- lc3b_types: add typedef lc3b_tag (TAG_W bits) and struct cdb_t {valid, tag, data}.
- macros.sv keeps NUM_STATIONS.
- One natural sub-module, onehot_decoder (SEL_W -> NUM_STATIONS, with an enable), used for station_clear.

Test Plan:
1. Reset, then load=1, sel=2, tag[2]=5, data[2]=0x1234, rob_ready=1 -> next cycle cdb_valid=1, tag=5, data=0x1234, station_clear=4'b0100; the cycle after, clear=0.
2. Back-to-back grants sel=0 then sel=3, rob_ready=1 -> two consecutive valid cycles with tags of st0 then st3, clears 0001 then 1000, bcast_count=2.
3. Capture sel=1, hold rob_ready=0 for 3 cycles while load=1, sel=0 -> CDB holds st1 values, no further clear pulses. Raise rob_ready -> next cycle st0 is broadcast with clear=0001.
4. cdb_valid=1 with flush=1 and load=1 -> next cycle cdb_valid=0, station_clear=0.
5. load=1, selection=4 with NUM_STATIONS=4 -> cdb_valid stays 0, no clear.
6. Preload bcast_count near wrap (0xFFFE), then 3 accepts -> count reads 0xFFFF, then 0x0000, then 0x0001. Assert reset mid-broadcast -> all outputs 0 next cycle.
